// File: rtl/sbox_seq_ctrl.sv
// rtl/sbox_seq_ctrl.sv - byte-serial sequencer feeding a shared masked S-box pipeline
// Optional stall counter port enabled by defining SBOX_CTRL_STALL_CNT_EN.
module sbox_seq_ctrl #(
  parameter int d   = 2,
  parameter int LAT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [32*d-1:0] in_data,
  input  logic            rnd_valid,
  output logic            rnd_ready,
  output logic [8*d-1:0]  sb_in,
  output logic            sb_valid,
  input  logic [8*d-1:0]  sb_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [32*d-1:0] out_data
`ifdef SBOX_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]     stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t          state;
  logic [1:0]      k;
  logic [32*d-1:0] word_q;
  logic [LAT-1:0]  pv;
  logic [1:0]      pidx [LAT];
  logic            issue;

  assign issue     = (state == FEED) && rnd_valid;
  assign sb_valid  = issue;
  assign rnd_ready = issue;
  assign in_ready  = (state == IDLE);

  // Bus is forced to zero between issues so no share lingers on it.
  always_comb begin
    sb_in = '0;
    if (issue) begin
      for (int s = 0; s < d; s++) begin
        sb_in[8*s +: 8] = word_q[32*s + {k, 3'b000} +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= 2'd0;
      word_q    <= '0;
      pv        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < LAT; i++) begin
        pidx[i] <= 2'd0;
      end
    end else begin
      pv[0]   <= issue;
      pidx[0] <= k;
      for (int i = 1; i < LAT; i++) begin
        pv[i]   <= pv[i-1];
        pidx[i] <= pidx[i-1];
      end

      // The tail of the tracker lines up with the S-box result of that issue.
      if (pv[LAT-1]) begin
        for (int s = 0; s < d; s++) begin
          out_data[32*s + {pidx[LAT-1], 3'b000} +: 8] <= sb_out[8*s +: 8];
        end
      end

      case (state)
        IDLE: begin
          if (in_valid) begin
            word_q <= in_data;
            k      <= 2'd0;
            state  <= FEED;
          end
        end
        FEED: begin
          if (rnd_valid) begin
            k <= k + 2'd1;
            if (k == 2'd3) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pv[LAT-1] && (pidx[LAT-1] == 2'd3)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SBOX_CTRL_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'd0;
    end else if ((state == FEED) && !rnd_valid && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sbox_seq_ctrl.sv
// tb/tb_sbox_seq_ctrl.sv - directed bench for sbox_seq_ctrl with a masked S-box pipeline model
// Stall counter checks are compiled in when SBOX_CTRL_STALL_CNT_EN is defined.
module tb_sbox_seq_ctrl;
  localparam int D = 2;
  localparam int L = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          rnd_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [63:0]   in_data = '0;
  logic          in_ready, rnd_ready, sb_valid, out_valid;
  logic [15:0]   sb_in, sb_out;
  logic [63:0]   out_data;
`ifdef SBOX_CTRL_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] pipe [L];
  logic [7:0]  r8;

  always #5 clk = ~clk;

  sbox_seq_ctrl #(.d(D), .LAT(L)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .sb_in     (sb_in),
    .sb_valid  (sb_valid),
    .sb_out    (sb_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SBOX_CTRL_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  function automatic logic [7:0] sbox(input logic [7:0] x);
    case (x)
      8'h00:   sbox = 8'h63;
      8'h01:   sbox = 8'h7c;
      8'h02:   sbox = 8'h77;
      8'h03:   sbox = 8'h7b;
      8'hF6:   sbox = 8'h42;
      default: sbox = 8'h00;
    endcase
  endfunction

  // Remasked S-box with fixed latency; idle slots carry a recognisable junk pattern.
  always @(posedge clk) begin
    r8 = 8'($urandom);
    pipe[0] <= sb_valid ? {r8, sbox(sb_in[7:0] ^ sb_in[15:8]) ^ r8} : 16'h11EE;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign sb_out = pipe[L-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_word(input string name, input logic [31:0] s0, input logic [31:0] s1,
                          input logic [31:0] exp, input int nbub, input int hold);
    int pulses, bub_left, lat, last_pulse;
    logic done;
    logic [63:0] held;
    @(negedge clk);
    check({name, "_in_ready"}, in_ready, 1);
    in_valid  = 1'b1;
    in_data   = {s1, s0};
    rnd_valid = 1'b1;
    pulses = 0; bub_left = nbub; lat = -1; last_pulse = -1; done = 1'b0;
    for (int i = 1; i <= nbub + L + 40 && !done; i++) begin
      @(negedge clk);
      in_data   = ~{s1, s0};
      rnd_valid = !(pulses == 2 && bub_left > 0);
      if (!rnd_valid) bub_left--;
      #1;
      if (i < 40) check({name, "_rnd_ready"}, rnd_ready, sb_valid);
      if (sb_valid) begin
        if (pulses < 4) check({name, "_sb_in"}, sb_in, {s1[8*pulses +: 8], s0[8*pulses +: 8]});
        else check({name, "_extra_issue"}, pulses, 3);
        last_pulse = i;
        pulses++;
      end else if (!rnd_valid && nbub < 100) begin
        check({name, "_bubble_sb_in"}, sb_in, 0);
      end
      if (out_valid) begin
        done = 1'b1;
        lat  = i - 1;
      end
    end
    check({name, "_latency"}, lat, 8 + nbub);
    check({name, "_pulses"}, pulses, 4);
    check({name, "_last_issue"}, last_pulse, 4 + nbub);
    check({name, "_result"}, out_data[31:0] ^ out_data[63:32], exp);
    check({name, "_busy"}, in_ready, 0);
    held = out_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({name, "_hold_valid"}, out_valid, 1);
      check({name, "_hold_data"}, out_data, held);
      check({name, "_hold_ready"}, in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_release_valid"}, out_valid, 0);
    check({name, "_release_ready"}, in_ready, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_sb_valid", sb_valid, 0);
    check("reset_sb_in", sb_in, 0);
    check("reset_out_data", out_data, 0);
`ifdef SBOX_CTRL_STALL_CNT_EN
    check("reset_stall_cnt", stall_cnt, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", in_ready, 1);

    run_word("zero", 32'h00000000, 32'h00000000, 32'h63636363, 0, 0);
    run_word("f6", 32'h53535353, 32'hA5A5A5A5, 32'h42424242, 0, 0);
    run_word("bubble", 32'h03020100, 32'h00000000, 32'h7b777c63, 3, 10);
`ifdef SBOX_CTRL_STALL_CNT_EN
    check("stall_cnt_3", stall_cnt, 3);
`endif

    // Reset while the pipeline still holds bytes 2 and 3 of this word.
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = {32'h00000000, 32'h03020100};
    rnd_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("drain_busy", in_ready, 0);
    rst_n = 1'b0;
    #2;
    check("async_rst_out_data", out_data, 0);
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_sb_valid", sb_valid, 0);
`ifdef SBOX_CTRL_STALL_CNT_EN
    check("async_rst_stall_cnt", stall_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    repeat (3) @(negedge clk);
    check("no_stale_capture", out_data, 0);
    check("no_stale_done", out_valid, 0);
    run_word("after_rst", 32'h00000000, 32'h00000000, 32'h63636363, 0, 0);

`ifdef SBOX_CTRL_STALL_CNT_EN
    run_word("saturate", 32'h00000000, 32'h00000000, 32'h63636363, 70000, 0);
    check("stall_cnt_sat", stall_cnt, 16'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/sbox_seq_ctrl.md
SBOX_SEQ_CTRL -- requirements
Module: sbox_seq_ctrl

Interface
REQ-001 SHALL have parameter d, default 2: number of masking shares.
REQ-002 SHALL have parameter LAT, default 4: fixed latency of the shared masked S-box pipeline, in cycles, with no enable and no stall (1..8).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: a 32-bit masked word is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the controller accepts the word this cycle.
REQ-007 SHALL have port in_data, input, 32*d bits: share s in [32*s+31:32*s]; byte k of share s in [32*s+8k+7:32*s+8k].
REQ-008 SHALL have port rnd_valid, input, 1 bit: fresh S-box randomness is available this cycle.
REQ-009 SHALL have port rnd_ready, output, 1 bit: randomness is consumed this cycle; equal to sb_valid.
REQ-010 SHALL have port sb_in, output, 8*d bits: byte to the S-box, with share s in [8*s+7:8*s].
REQ-011 SHALL have port sb_valid, output, 1 bit: sb_in carries a real issue this cycle.
REQ-012 SHALL have port sb_out, input, 8*d bits: S-box result, LAT cycles after issue, same share layout.
REQ-013 SHALL have port out_valid, output, 1 bit: out_data holds a complete substituted word.
REQ-014 SHALL have port out_ready, input, 1 bit: the consumer takes out_data.
REQ-015 SHALL have port out_data, output, 32*d bits: substituted word, same layout as in_data.
REQ-016 SHALL have port stall_cnt, output, 16 bits: present only when SBOX_CTRL_STALL_CNT_EN is defined.

Function
REQ-017 SHALL implement the FSM states IDLE, FEED, DRAIN and DONE.
REQ-018 SHALL assert in_ready only in IDLE; in_valid&&in_ready SHALL latch in_data and move to FEED with byte index 0.
REQ-019 SHALL, in FEED, issue byte k (0..3) in ascending order, one per cycle, only when rnd_valid=1: sb_valid=1, sb_in=byte k, k increments.
REQ-020 SHALL, in FEED with rnd_valid=0, issue nothing: sb_valid=0, k holds; this is a bubble.
REQ-021 SHALL move to DRAIN after issuing byte 3.
REQ-022 SHALL track issues with a LAT-deep shift register of {valid, 2-bit byte index}; when its tail is valid, sb_out SHALL be written into out_data byte slot idx for all shares.
REQ-023 SHALL move from DRAIN to DONE in the cycle byte 3's result is captured; out_valid=1 from the next cycle.
REQ-024 SHALL, in DONE, hold out_data and out_valid stable until out_ready=1, then return to IDLE; out_valid=0 and in_ready=1 from the next cycle.
REQ-025 SHALL hold sb_in at all-zero whenever sb_valid=0, so no share value sits idle on the bus.
REQ-026 SHALL give a minimum latency from input accept to out_valid of 4+LAT cycles with no bubbles; each bubble SHALL add exactly one cycle.
REQ-027 SHALL ignore in_valid outside IDLE; a word is never overwritten mid-operation.

Reset
REQ-028 SHALL, on rst_n=0 (asynchronous), reset as follows: state=IDLE, k=0, shift register cleared, out_data=0, out_valid=0, sb_valid=0, sb_in=0, stall_cnt=0.
REQ-029 SHALL, on reset mid-operation, discard all in-flight issues; later sb_out values SHALL NOT be captured.
REQ-030 SHALL assert in_ready in the first cycle after rst_n deasserts.

Configuration
REQ-031 SHALL, with SBOX_CTRL_STALL_CNT_EN defined, increment stall_cnt on each FEED cycle with rnd_valid=0, saturating at 0xFFFF; stall_cnt is cleared only by reset.
REQ-032 SHALL, without SBOX_CTRL_STALL_CNT_EN, omit the stall_cnt port and its counter; all other behaviour is identical.

Verification
REQ-033 SHALL cover: d=2, LAT=4, share0=0x00000000, share1=0, rnd_valid=1 -> out_valid 8 cycles after accept; share0^share1 = 0x63636363.
REQ-034 SHALL cover: share0=0x53535353, share1=0xA5A5A5A5 (value 0xF6F6F6F6) -> share0^share1 = 0x42424242, with four sb_valid pulses in consecutive cycles.
REQ-035 SHALL cover: rnd_valid low for 3 cycles after byte 1 -> out_valid at accept+11; stall_cnt=3 when enabled; sb_in=0 during the bubbles.
REQ-036 SHALL cover: out_ready held low 10 cycles in DONE -> out_data stable and in_ready=0 throughout; IDLE entered on the cycle after out_ready=1.
REQ-037 SHALL cover: rst_n pulsed low during DRAIN, then a new word 0x00000000 -> out_data holds only the new word's results (0x63636363), no stale bytes.
REQ-038 SHALL cover: rnd_valid=0 for 70000 FEED cycles with the macro defined -> stall_cnt saturates at 0xFFFF.
